// File: rtl/reg_file_if.sv
// reg_file_if: register-file read/write bus between the datapath and the register file
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  regWrite;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    modport master (
        output readReg1, readReg2, writeReg, writeData, regWrite,
        input  readData1, readData2
    );

    modport slave (
        input  readReg1, readReg2, writeReg, writeData, regWrite,
        output readData1, readData2
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 MIPS register file, two combinational reads, one synchronous write, $zero hardwired
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input logic     clk,
    input logic     reset,
    reg_file_if.slave bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // reset clears everything and wins over a same-cycle write; index 0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (bus.regWrite && bus.writeReg != '0) begin
            regs[bus.writeReg] <= bus.writeData;
        end
    end

    // reads are unbypassed; index 0 forced to zero so it holds even before the first reset
    always_comb begin
        bus.readData1 = bus.readReg1 == '0 ? '0 : regs[bus.readReg1];
        bus.readData2 = bus.readReg2 == '0 ? '0 : regs[bus.readReg2];
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file against a reference register array
module tb_reg_file;
    logic clk = 0;
    logic reset;
    int total = 0;
    int bad = 0;
    logic [31:0] model [32];
    logic [31:0] sb [$];

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one rising edge; the reference array follows the held inputs
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 0;
        end else if (bus.regWrite && bus.writeReg != 0) begin
            model[bus.writeReg] = bus.writeData;
        end
        #1;
    endtask

    task automatic readCheck(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.readReg1 = a1;
        bus.readReg2 = a2;
        sb.push_back(model[a1]);
        sb.push_back(model[a2]);
        #1;
        check({tag, ".rd1"}, bus.readData1, sb.pop_front());
        check({tag, ".rd2"}, bus.readData2, sb.pop_front());
    endtask

    task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic we);
        bus.writeReg = a;
        bus.writeData = d;
        bus.regWrite = we;
        tick();
        bus.regWrite = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        reset = 1;
        bus.readReg1 = 0;
        bus.readReg2 = 0;
        bus.writeReg = 0;
        bus.writeData = 0;
        bus.regWrite = 0;
        tick();
        reset = 0;
        readCheck("rst0", 0, 0);
        readCheck("rst1", 1, 31);
        readCheck("rst31", 31, 1);

        bus.regWrite = 1;
        bus.writeData = 32'd10;
        for (int i = 0; i < 32; i++) begin
            bus.writeReg = 5'(i);
            tick();
        end
        bus.regWrite = 0;
        readCheck("fill0", 0, 2);
        check("fill.const", bus.readData2, 32'd10);
        for (int i = 1; i < 32; i++) readCheck("fillAll", 5'(i), 5'(32 - i));

        doWrite(5, 32'hDEADBEEF, 0);
        readCheck("noWe", 5, 5);
        check("noWe.const", bus.readData1, 32'd10);
        doWrite(5, 32'hDEADBEEF, 1);
        readCheck("we", 5, 5);
        check("we.const", bus.readData1, 32'hDEADBEEF);

        bus.writeReg = 7;
        bus.writeData = 32'h1234;
        bus.regWrite = 1;
        readCheck("rdwOld", 7, 7);
        check("rdwOld.const", bus.readData1, 32'd10);
        tick();
        bus.regWrite = 0;
        readCheck("rdwNew", 7, 7);
        check("rdwNew.const", bus.readData2, 32'h1234);

        doWrite(31, 32'hFFFFFFFF, 1);
        doWrite(1, 32'hA5A5A5A5, 1);
        readCheck("pre31", 31, 1);
        bus.writeReg = 3;
        bus.writeData = 32'h55AA55AA;
        bus.regWrite = 1;
        reset = 1;
        tick();
        reset = 0;
        bus.regWrite = 0;
        for (int i = 0; i < 32; i++) readCheck("midRst", 5'(i), 5'(31 - i));
        bus.readReg1 = 3;
        #1;
        check("midRst3.const", bus.readData1, 32'd0);

        doWrite(0, 32'hCAFEF00D, 1);
        readCheck("zero", 0, 0);
        check("zero.const", bus.readData1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
